lif_neuron_scheduler: RTL and testbench
=======================================

// Module: lif_neuron_scheduler
// PURPOSE
//   Time-multiplexes one shared LIF (leaky integrate-and-fire) update datapath across
//   N_NEURONS virtual neurons. Holds every membrane potential in an internal register
//   array, and on each timestep tick sequences the neurons in index order through the
//   datapath. Publishes the spike vector for that timestep. Sits between the tt_um_lif_test top I/O and the LIF core.
// PARAMETERS
//   N_NEURONS  4  number of virtual neurons (>=2); index width IW = $clog2(N_NEURONS)
//   WIDTH      8  membrane-potential and input-current width, unsigned
// PORTS
//   clk            in   1       system clock, all state on rising edge
//   rst_n          in   1       asynchronous active-low reset
//   ena            in   1       design enable; gates acceptance of tick only
//   tick           in   1       start one timestep (sampled in IDLE only)
//   clr_overrun    in   1       clears sticky overrun flag
//   cur_idx        out  IW      neuron index whose input current is requested
//   cur_in         in   WIDTH   input current for neuron cur_idx (combinational from top)
//   dp_valid       out  1       request to datapath; held until dp_ready
//   dp_ready       in   1       datapath accepts request
//   dp_state       out  WIDTH   membrane potential of current neuron
//   dp_current     out  WIDTH   captured input current of current neuron
//   dp_done        in   1       datapath result valid (one-cycle pulse)
//   dp_state_next  in   WIDTH   updated membrane potential
//   dp_spike       in   1       neuron fired this update
//   spikes         out  N       spike vector of last completed timestep
//   step_done      out  1       one-cycle pulse: timestep complete, spikes updated
//   busy           out  1       high in any state other than IDLE
//   overrun        out  1       sticky: tick arrived while busy
//   dbg_idx        in   IW      debug read index
//   dbg_vmem       out  WIDTH   membrane[dbg_idx], combinational read
// BEHAVIOUR
//   Reset: state=IDLE, all membranes=0, spikes=0, spike_acc=0, idx=0, dp_valid=0,
//     dp_state=0, dp_current=0, step_done=0, overrun=0, cur_idx=0. Async assert, sync release.
//   FSM: IDLE -> LOAD on (tick & ena). LOAD: cur_idx=idx; capture cur_in into dp_current,
//     membrane[idx] into dp_state at end of cycle -> ISSUE. ISSUE: dp_valid=1; on dp_ready
//     -> WAIT (dp_valid, dp_state, dp_current stable while stalled). WAIT: on dp_done
//     capture dp_state_next, dp_spike -> WRITE. WRITE: membrane[idx]<=result,
//     spike_acc[idx]<=spike; if idx==N-1 then idx<=0, spikes<=spike_acc (incl. this bit)
//     -> DONE, else idx++ -> LOAD. DONE: step_done=1 for exactly this cycle -> IDLE.
//   Latency: zero-wait datapath (dp_ready=1, dp_done one cycle after handshake) gives
//     step_done high 4*N_NEURONS+1 cycles after the edge that sampled tick.
//   spikes changes only on the DONE transition; stable for a full timestep otherwise.
//   tick while busy: ignored, overrun<=1. clr_overrun & simultaneous overrun event: set wins.
//   tick with ena=0: ignored, no overrun. ena falling mid-step: step completes normally.
//   dp_done outside WAIT: ignored. dp_ready outside ISSUE: ignored.
//   No arithmetic in this block; result stored verbatim (saturation/leak owned by datapath).
//   Reset mid-step: dp_valid drops immediately, membranes cleared, step abandoned.
// TESTING
//   1. Reset, dp_ready=1, dp_done 1 cycle after handshake, N=4, tick -> step_done exactly
//      17 cycles later; cur_idx sequence 0,1,2,3; busy high 17 cycles.
//   2. Model datapath V'=V+I, spike when >=200 (then V'=0); cur_in=60 for all -> spikes=0,0,0,
//      then 4'b1111 on step 4; dbg_vmem per index tracks 60,120,180,0.
//   3. dp_ready held low 5 cycles in ISSUE for neuron 2 -> dp_valid/dp_state/dp_current
//      stable throughout; step_done delayed by exactly 5 cycles.
//   4. Second tick at cycle 3 of a step -> ignored, overrun=1 until clr_overrun; tick with
//      ena=0 -> no activity, overrun unchanged.
//   5. Spurious dp_done in IDLE and LOAD -> no membrane or spike change.
//   6. rst_n low in WAIT of neuron 1 -> dp_valid=0, busy=0, all dbg_vmem=0, spikes=0 at once.

Source files
------------

// File: rtl/lif_neuron_scheduler.sv
// -----------------------------------------------------------------------------
// lif_neuron_scheduler
//
// Time-multiplexes one shared leaky integrate-and-fire update datapath across
// N_NEURONS virtual neurons. Every membrane potential lives in an internal
// register array. Each accepted tick walks the neurons in index order through
// LOAD -> ISSUE -> WAIT -> WRITE. After the last neuron it publishes the spike
// vector for the timestep and pulses step_done.
//
// Ports
//   clk, rst_n     clock (rising edge) and asynchronous active-low reset
//   ena            gates acceptance of tick; an in-flight step always completes
//   tick           starts one timestep when the scheduler is idle
//   clr_overrun    clears the sticky overrun flag (a simultaneous set wins)
//   cur_idx        neuron whose input current the top level must present
//   cur_in         input current for cur_idx, captured at the end of LOAD
//   dp_valid/ready request handshake towards the datapath
//   dp_state       membrane potential of the neuron being updated
//   dp_current     captured input current of the neuron being updated
//   dp_done        one-cycle result strobe from the datapath
//   dp_state_next  updated membrane potential, stored verbatim
//   dp_spike       neuron fired during this update
//   spikes         spike vector of the last completed timestep
//   step_done      one-cycle pulse: timestep complete, spikes updated
//   busy           scheduler is not idle
//   overrun        sticky: a tick arrived while busy
//   dbg_idx        debug read index
//   dbg_vmem       membrane[dbg_idx], combinational read
// -----------------------------------------------------------------------------
module lif_neuron_scheduler #(
   parameter  int N_NEURONS = 4,
   parameter  int WIDTH     = 8,
   localparam int IW        = $clog2(N_NEURONS)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 ena,
   input  logic                 tick,
   input  logic                 clr_overrun,
   output logic [IW-1:0]        cur_idx,
   input  logic [WIDTH-1:0]     cur_in,
   output logic                 dp_valid,
   input  logic                 dp_ready,
   output logic [WIDTH-1:0]     dp_state,
   output logic [WIDTH-1:0]     dp_current,
   input  logic                 dp_done,
   input  logic [WIDTH-1:0]     dp_state_next,
   input  logic                 dp_spike,
   output logic [N_NEURONS-1:0] spikes,
   output logic                 step_done,
   output logic                 busy,
   output logic                 overrun,
   input  logic [IW-1:0]        dbg_idx,
   output logic [WIDTH-1:0]     dbg_vmem
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_ISSUE,
      S_WAIT,
      S_WRITE,
      S_DONE
   } state_t;

   state_t               state_q,      state_d;
   logic [IW-1:0]        idx_q,        idx_d;
   logic [WIDTH-1:0]     mem_q [N_NEURONS];
   logic [WIDTH-1:0]     mem_d [N_NEURONS];
   logic [N_NEURONS-1:0] spike_acc_q,  spike_acc_d;
   logic [N_NEURONS-1:0] spikes_q,     spikes_d;
   logic [WIDTH-1:0]     dp_state_q,   dp_state_d;
   logic [WIDTH-1:0]     dp_current_q, dp_current_d;
   logic [WIDTH-1:0]     res_state_q,  res_state_d;
   logic                 res_spike_q,  res_spike_d;
   logic                 dp_valid_q,   dp_valid_d;
   logic                 step_done_q,  step_done_d;
   logic                 overrun_q,    overrun_d;
   logic                 last_idx;

   assign last_idx = (idx_q == IW'(N_NEURONS - 1));

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      // NOTE: every variable gets a default here so no path can leave one
      // unassigned, which would otherwise infer a latch.
      state_d      = state_q;
      idx_d        = idx_q;
      mem_d        = mem_q;
      spike_acc_d  = spike_acc_q;
      spikes_d     = spikes_q;
      dp_state_d   = dp_state_q;
      dp_current_d = dp_current_q;
      res_state_d  = res_state_q;
      res_spike_d  = res_spike_q;
      dp_valid_d   = dp_valid_q;
      step_done_d  = 1'b0;
      overrun_d    = overrun_q;

      case (state_q)
         S_IDLE: begin
            if (tick && ena) state_d = S_LOAD;
         end
         S_LOAD: begin
            // Operands are frozen here so they stay stable however long the
            // datapath stalls the handshake.
            dp_state_d   = mem_q[idx_q];
            dp_current_d = cur_in;
            dp_valid_d   = 1'b1;
            state_d      = S_ISSUE;
         end
         S_ISSUE: begin
            if (dp_ready) begin
               dp_valid_d = 1'b0;
               state_d    = S_WAIT;
            end
         end
         S_WAIT: begin
            if (dp_done) begin
               res_state_d = dp_state_next;
               res_spike_d = dp_spike;
               state_d     = S_WRITE;
            end
         end
         S_WRITE: begin
            mem_d[idx_q]       = res_state_q;
            spike_acc_d[idx_q] = res_spike_q;
            if (last_idx) begin
               // Publish the accumulator including the bit written just above.
               idx_d       = '0;
               spikes_d    = spike_acc_d;
               step_done_d = 1'b1;
               state_d     = S_DONE;
            end else begin
               idx_d   = idx_q + 1'b1;
               state_d = S_LOAD;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Set is evaluated after clear so a same-cycle overrun event wins.
      if (clr_overrun) overrun_d = 1'b0;
      if (tick && ena && (state_q != S_IDLE)) overrun_d = 1'b1;
   end

   // -------------------------------------------------------------------------
   // State registers
   // -------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the values from before the edge, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         idx_q        <= '0;
         // NOTE: the membrane array is reset on purpose: reset must abandon the
         // step and return every neuron to a zero potential.
         mem_q        <= '{default: '0};
         spike_acc_q  <= '0;
         spikes_q     <= '0;
         dp_state_q   <= '0;
         dp_current_q <= '0;
         res_state_q  <= '0;
         res_spike_q  <= 1'b0;
         dp_valid_q   <= 1'b0;
         step_done_q  <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         mem_q        <= mem_d;
         spike_acc_q  <= spike_acc_d;
         spikes_q     <= spikes_d;
         dp_state_q   <= dp_state_d;
         dp_current_q <= dp_current_d;
         res_state_q  <= res_state_d;
         res_spike_q  <= res_spike_d;
         dp_valid_q   <= dp_valid_d;
         step_done_q  <= step_done_d;
         overrun_q    <= overrun_d;
      end
   end

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   assign cur_idx    = idx_q;
   assign dp_valid   = dp_valid_q;
   assign dp_state   = dp_state_q;
   assign dp_current = dp_current_q;
   assign spikes     = spikes_q;
   assign step_done  = step_done_q;
   assign busy       = (state_q != S_IDLE);
   assign overrun    = overrun_q;

   // Explicit mux so an index beyond N_NEURONS-1 reads zero when N_NEURONS is
   // not a power of two.
   always_comb begin
      dbg_vmem = '0;
      for (int i = 0; i < N_NEURONS; i++) begin
         if (dbg_idx == IW'(i)) dbg_vmem = mem_q[i];
      end
   end

endmodule

// File: tb/tb_lif_neuron_scheduler.sv
// -----------------------------------------------------------------------------
// tb_lif_neuron_scheduler
//
// Drives lif_neuron_scheduler with a behavioural datapath (V' = V + I, fire
// and reset to 0 when the sum reaches 200) and compares latency, index order,
// handshake stability, overrun handling, spike vectors and membrane values
// against a per-timestep reference model of the whole neuron array.
// -----------------------------------------------------------------------------
module tb_lif_neuron_scheduler;

   localparam int N  = 4;
   localparam int W  = 8;
   localparam int IW = 2;

   logic          clk = 1'b0;
   logic          rst_n, ena, tick, clr_overrun;
   logic [IW-1:0] cur_idx, dbg_idx;
   logic [W-1:0]  cur_in, dp_state, dp_current, dp_state_next, dbg_vmem;
   logic          dp_valid, dp_done, dp_spike;
   logic          dp_ready = 1'b1;
   logic [N-1:0]  spikes;
   logic          step_done, busy, overrun;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   lif_neuron_scheduler #(.N_NEURONS(N), .WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .tick(tick), .clr_overrun(clr_overrun),
      .cur_idx(cur_idx), .cur_in(cur_in),
      .dp_valid(dp_valid), .dp_ready(dp_ready), .dp_state(dp_state), .dp_current(dp_current),
      .dp_done(dp_done), .dp_state_next(dp_state_next), .dp_spike(dp_spike),
      .spikes(spikes), .step_done(step_done), .busy(busy), .overrun(overrun),
      .dbg_idx(dbg_idx), .dbg_vmem(dbg_vmem)
   );

   // Input currents presented by the top level, indexed by the requested neuron.
   logic [W-1:0] cur_tab [N];
   assign cur_in = cur_tab[cur_idx];

   // LIF rule: {spike, new potential}.
   function automatic logic [W:0] lif(input logic [W-1:0] v, input logic [W-1:0] i);
      int s;
      s = int'(v) + int'(i);
      if (s >= 200) return {1'b1, {W{1'b0}}};
      return {1'b0, W'(s)};
   endfunction

   // ---------------------------------------------------------------------------
   // Behavioural datapath: accepts a request, answers one cycle after handshake.
   // Optional stall of dp_ready for one neuron, with operand-stability tracking.
   // ---------------------------------------------------------------------------
   logic         resp_done = 1'b0, resp_spike = 1'b0, spur_done = 1'b0;
   logic [W-1:0] resp_next = '0;
   bit           hs_pending = 1'b0;
   logic [W:0]   pend_res;
   int           stall_idx = -1, stall_left = 0, stall_seen = 0;
   bit           stall_bad = 1'b0;
   logic [W-1:0] stall_state, stall_cur;

   assign dp_done       = resp_done | spur_done;
   assign dp_state_next = spur_done ? 8'hA5 : resp_next;
   assign dp_spike      = spur_done ? 1'b1  : resp_spike;

   always @(negedge clk) begin
      resp_done = 1'b0;
      if (!rst_n) begin
         hs_pending = 1'b0;
         dp_ready   = 1'b1;
      end else begin
         if (hs_pending) begin
            resp_done  = 1'b1;
            resp_next  = pend_res[W-1:0];
            resp_spike = pend_res[W];
            hs_pending = 1'b0;
         end
         dp_ready = 1'b1;
         if (dp_valid && int'(cur_idx) == stall_idx && stall_left > 0) begin
            if (stall_seen == 0) begin
               stall_state = dp_state;
               stall_cur   = dp_current;
            end else if (dp_state !== stall_state || dp_current !== stall_cur) begin
               stall_bad = 1'b1;
            end
            stall_seen++;
            stall_left--;
            dp_ready = 1'b0;
         end
         if (dp_valid && dp_ready) begin
            if (int'(cur_idx) == stall_idx && stall_seen > 0 &&
                (dp_state !== stall_state || dp_current !== stall_cur)) stall_bad = 1'b1;
            pend_res   = lif(dp_state, dp_current);
            hs_pending = 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Reference model: whole-array update per timestep
   // ---------------------------------------------------------------------------
   logic [W-1:0] model_v [N];
   logic [N-1:0] model_spk;

   task automatic model_step();
      logic [W:0] r;
      for (int i = 0; i < N; i++) begin
         r            = lif(model_v[i], cur_tab[i]);
         model_v[i]   = r[W-1:0];
         model_spk[i] = r[W];
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) model_v[i] = '0;
      model_spk = '0;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_model(input string tag);
      chk({tag, "_spikes"}, 32'(spikes), 32'(model_spk));
      for (int i = 0; i < N; i++) begin
         dbg_idx = IW'(i);
         #1;
         chk($sformatf("%s_vmem%0d", tag, i), 32'(dbg_vmem), 32'(model_v[i]));
      end
   endtask

   // ---------------------------------------------------------------------------
   // One timestep. Starts and ends just after a falling edge. k counts rising
   // edges after the one that sampled tick; observations are taken on the
   // falling edge before edge k.
   // ---------------------------------------------------------------------------
   int           lat, busy_cnt, nrise;
   logic [7:0]   seq;
   bit           spk_moved;
   logic         done_after, busy_after;

   task automatic run_step(input int stall_i, input int stall_n, input int tick2_at,
                           input bit clr_with, input int ena_drop_at, input int spur_at);
      logic [N-1:0] spk0;
      logic         prev_valid;
      lat = 0; busy_cnt = 0; nrise = 0; seq = '0; spk_moved = 1'b0; prev_valid = 1'b0;
      stall_idx = stall_i; stall_left = stall_n; stall_seen = 0; stall_bad = 1'b0;
      spk0 = spikes;
      tick = 1'b1;
      @(posedge clk);
      for (int k = 1; k <= 100 && lat == 0; k++) begin
         @(negedge clk);
         tick = 1'b0; clr_overrun = 1'b0; spur_done = 1'b0;
         if (k == tick2_at) begin
            tick        = 1'b1;
            clr_overrun = clr_with;
         end
         if (k == ena_drop_at) ena = 1'b0;
         if (k == spur_at) spur_done = 1'b1;
         if (busy) busy_cnt++;
         if (dp_valid && !prev_valid) begin
            seq = {seq[5:0], cur_idx};
            nrise++;
         end
         prev_valid = dp_valid;
         if (step_done) lat = k;
         else if (spikes !== spk0) spk_moved = 1'b1;
      end
      @(negedge clk);
      tick = 1'b0; clr_overrun = 1'b0; spur_done = 1'b0;
      done_after = step_done;
      busy_after = busy;
      ena = 1'b1;
      stall_idx = -1;
   endtask

   task automatic check_step(input string tag, input int exp_lat);
      model_step();
      chk({tag, "_latency"},    32'(lat),        32'(exp_lat));
      chk({tag, "_busy_cyc"},   32'(busy_cnt),   32'(exp_lat));
      chk({tag, "_idx_seq"},    32'(seq),        32'h1B);
      chk({tag, "_issues"},     32'(nrise),      32'd4);
      chk({tag, "_done_pulse"}, 32'(done_after), 32'd0);
      chk({tag, "_idle"},       32'(busy_after), 32'd0);
      chk({tag, "_spk_stable"}, 32'(spk_moved),  32'd0);
      check_model(tag);
   endtask

   // ---------------------------------------------------------------------------
   // Directed sequence
   // ---------------------------------------------------------------------------
   initial begin
      bit any_busy;
      rst_n = 1'b0; ena = 1'b1; tick = 1'b0; clr_overrun = 1'b0; dbg_idx = '0;
      for (int i = 0; i < N; i++) cur_tab[i] = '0;
      model_reset();

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_busy",       32'(busy),       32'd0);
      chk("rst_dp_valid",   32'(dp_valid),   32'd0);
      chk("rst_step_done",  32'(step_done),  32'd0);
      chk("rst_overrun",    32'(overrun),    32'd0);
      chk("rst_cur_idx",    32'(cur_idx),    32'd0);
      chk("rst_dp_state",   32'(dp_state),   32'd0);
      chk("rst_dp_current", 32'(dp_current), 32'd0);
      check_model("rst");
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Constant current 60: potentials 60,120,180 then all fire
      for (int i = 0; i < N; i++) cur_tab[i] = 8'd60;
      for (int s = 1; s <= 4; s++) begin
         run_step(-1, 0, 0, 1'b0, 0, 0);
         check_step($sformatf("c60_s%0d", s), 17);
      end
      chk("c60_all_fire", 32'(spikes), 32'hF);

      // Randomized currents
      for (int s = 0; s < 4; s++) begin
         for (int i = 0; i < N; i++) cur_tab[i] = 8'($urandom_range(0, 255));
         run_step(-1, 0, 0, 1'b0, 0, 0);
         check_step($sformatf("rnd_s%0d", s), 17);
      end

      // dp_ready held low 5 cycles for neuron 2
      for (int i = 0; i < N; i++) cur_tab[i] = 8'($urandom_range(0, 120));
      run_step(2, 5, 0, 1'b0, 0, 0);
      chk("stall_cycles", 32'(stall_seen), 32'd5);
      chk("stall_stable", 32'(stall_bad),  32'd0);
      check_step("stall", 22);

      // Second tick mid-step -> overrun, step unaffected
      run_step(-1, 0, 3, 1'b0, 0, 0);
      check_step("ovr", 17);
      chk("ovr_set", 32'(overrun), 32'd1);
      repeat (3) @(negedge clk);
      chk("ovr_sticky", 32'(overrun), 32'd1);

      // Tick with ena=0: no activity, overrun unchanged
      ena = 1'b0; tick = 1'b1; any_busy = 1'b0;
      repeat (4) begin
         @(negedge clk);
         tick = 1'b0;
         if (busy) any_busy = 1'b1;
      end
      ena = 1'b1;
      chk("ena0_no_busy",  32'(any_busy), 32'd0);
      chk("ena0_ovr_kept", 32'(overrun),  32'd1);
      check_model("ena0");

      // Clear overrun
      clr_overrun = 1'b1;
      @(negedge clk);
      clr_overrun = 1'b0;
      chk("ovr_cleared", 32'(overrun), 32'd0);

      // Clear coinciding with an overrun event: set wins
      run_step(-1, 0, 3, 1'b1, 0, 0);
      check_step("ovr_setwins", 17);
      chk("ovr_setwins_flag", 32'(overrun), 32'd1);
      clr_overrun = 1'b1;
      @(negedge clk);
      clr_overrun = 1'b0;
      chk("ovr_cleared2", 32'(overrun), 32'd0);

      // ena falling mid-step: step still completes
      for (int i = 0; i < N; i++) cur_tab[i] = 8'($urandom_range(0, 255));
      run_step(-1, 0, 0, 1'b0, 2, 0);
      check_step("ena_drop", 17);

      // Spurious dp_done in IDLE, then in LOAD
      spur_done = 1'b1;
      @(negedge clk);
      spur_done = 1'b0;
      @(negedge clk);
      chk("spur_idle_busy", 32'(busy), 32'd0);
      check_model("spur_idle");
      run_step(-1, 0, 0, 1'b0, 0, 1);
      check_step("spur_load", 17);

      // Known firing step, then reset while neuron 1 is in WAIT
      cur_tab[0] = 8'd250; cur_tab[1] = 8'd10; cur_tab[2] = 8'd250; cur_tab[3] = 8'd10;
      run_step(-1, 0, 0, 1'b0, 0, 0);
      check_step("pre_rst", 17);
      tick = 1'b1;
      @(posedge clk);
      @(negedge clk);
      tick = 1'b0;
      repeat (6) @(negedge clk);
      chk("mid_rst_idx",  32'(cur_idx), 32'd1);
      chk("mid_rst_busy", 32'(busy),    32'd1);
      rst_n = 1'b0;
      #1;
      model_reset();
      chk("mid_rst_dp_valid", 32'(dp_valid),  32'd0);
      chk("mid_rst_busy0",    32'(busy),      32'd0);
      chk("mid_rst_cur_idx",  32'(cur_idx),   32'd0);
      chk("mid_rst_done",     32'(step_done), 32'd0);
      check_model("mid_rst");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Recovery after reset
      for (int i = 0; i < N; i++) cur_tab[i] = 8'($urandom_range(0, 255));
      run_step(-1, 0, 0, 1'b0, 0, 0);
      check_step("post_rst", 17);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
